// File: rtl/oled_render_pkg.sv
// Shared types and constants for the BCD-to-OLED frame renderer: FSM states,
// glyph geometry and the 5x7 numeral font (column bytes, bit0 = top row).
package oled_render_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_FETCH = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam int GLYPH_W = 8;
  localparam logic [7:0] DASH_COL = 8'h08;

  // Indices 10..15 are non-BCD nibbles and all render as a dash.
  localparam logic [7:0] FONT_TABLE [16][8] = '{
    '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 8'h00, 8'h00},
    '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00, 8'h00, 8'h00},
    '{8'h21, 8'h41, 8'h45, 8'h4B, 8'h31, 8'h00, 8'h00, 8'h00},
    '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00, 8'h00, 8'h00},
    '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00, 8'h00, 8'h00},
    '{8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30, 8'h00, 8'h00, 8'h00},
    '{8'h01, 8'h71, 8'h09, 8'h05, 8'h03, 8'h00, 8'h00, 8'h00},
    '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00, 8'h00, 8'h00},
    '{8'h06, 8'h49, 8'h49, 8'h29, 8'h1E, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00},
    '{DASH_COL, DASH_COL, DASH_COL, DASH_COL, DASH_COL, 8'h00, 8'h00, 8'h00}
  };

endpackage

// File: rtl/oled_digit_font_rom.sv
// Registered glyph column lookup: one byte per (glyph, column), one cycle of
// latency; the blank input overrides the lookup with an all-zero column.
module oled_digit_font_rom
  import oled_render_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       blank,
  input  logic [3:0] glyph_idx,
  input  logic [2:0] glyph_col,
  output logic [7:0] byte_q
);

  // Output only moves on en, so a byte waiting for acceptance stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q <= 8'h00;
    end else if (en) begin
      byte_q <= blank ? 8'h00 : FONT_TABLE[glyph_idx][glyph_col];
    end
  end

endmodule

// File: rtl/bcd_oled_renderer.sv
// Streams one page-mode frame per request to the SSD1306 driver: a sync to
// (0,0), then COLS*PAGES column bytes with the BCD digits on one text page.
module bcd_oled_renderer
  import oled_render_pkg::*;
#(
  parameter int DIGITS_NUM    = 6,
  parameter int COLS          = 128,
  parameter int PAGES         = 8,
  parameter int TEXT_PAGE     = 3,
  parameter int TEXT_X0       = 40,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk_in,
  input  logic                    resetn_in,
  input  logic [4*DIGITS_NUM-1:0] digits_in,
  input  logic                    frame_stb_in,
  input  logic                    ready_in,
  output logic [7:0]              data_out,
  output logic                    write_stb_out,
  output logic                    sync_stb_out,
  output logic                    busy_out,
  output logic                    frame_done_out,
  output logic [2:0]              state_dbg
);

  // Handshake: a strobe (sync or write) transfers on a rising edge where it
  // and ready_in are both high; it is held with stable data until then, and
  // is followed by at least one low cycle.

  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int TEXT_W = GLYPH_W * DIGITS_NUM;

  state_t                  state_q, state_d;
  logic [4*DIGITS_NUM-1:0] snap_q;
  logic [COL_W-1:0]        col_q;
  logic [PAGE_W-1:0]       page_q;
  logic                    pending_q, after_sync_q, last_q;
  logic                    latch, fetch_en, sync_stb, write_stb, done;
  logic                    sync_acc, write_acc;
  logic [DIGITS_NUM-1:0]   blank_mask;
  logic                    lead_zero;
  int                      k_i, d_i;
  logic                    in_text, glyph_blank;
  logic [3:0]              glyph_idx;
  logic [2:0]              glyph_col;
  logic                    col_last, page_last;

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch     = 1'b0;
    fetch_en  = 1'b0;
    sync_stb  = 1'b0;
    write_stb = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_stb_in) begin
          latch   = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        sync_stb = 1'b1;
        if (ready_in) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (after_sync_q) begin
          state_d = ST_FETCH;
        end else if (last_q) begin
          done = 1'b1;
          // A queued request restarts straight into SYNC with a fresh snapshot.
          if (pending_q || frame_stb_in) begin
            latch   = 1'b1;
            state_d = ST_SYNC;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        write_stb = 1'b1;
        if (ready_in) state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sync_acc  = sync_stb & ready_in;
  assign write_acc = write_stb & ready_in;
  assign col_last  = (col_q == COL_W'(COLS - 1));
  assign page_last = (page_q == PAGE_W'(PAGES - 1));

  always_ff @(posedge clk_in or negedge resetn_in) begin
    if (!resetn_in) begin
      snap_q       <= '0;
      col_q        <= '0;
      page_q       <= '0;
      pending_q    <= 1'b0;
      after_sync_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      if (latch) begin
        snap_q       <= digits_in;
        col_q        <= '0;
        page_q       <= '0;
        pending_q    <= 1'b0;
        after_sync_q <= 1'b0;
        last_q       <= 1'b0;
      end else if (frame_stb_in && (state_q != ST_IDLE)) begin
        pending_q <= 1'b1;
      end
      if (sync_acc) after_sync_q <= 1'b1;
      if (write_acc) begin
        after_sync_q <= 1'b0;
        last_q       <= col_last && page_last;
        if (col_last) begin
          col_q  <= '0;
          page_q <= page_last ? '0 : page_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Leading-zero blanking walks down from the most significant digit.
  always_comb begin
    lead_zero  = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS_NUM - 1; i >= 0; i--) begin
      lead_zero     = lead_zero & (snap_q[4*i +: 4] == 4'd0);
      blank_mask[i] = (BLANK_LEADING != 0) && (i != 0) && lead_zero;
    end
  end

  always_comb begin
    k_i         = int'(col_q) - TEXT_X0;
    in_text     = (int'(page_q) == TEXT_PAGE) && (k_i >= 0) && (k_i < TEXT_W);
    d_i         = in_text ? (DIGITS_NUM - 1 - k_i / GLYPH_W) : 0;
    glyph_idx   = 4'(snap_q >> (4 * d_i));
    glyph_col   = 3'(k_i % GLYPH_W);
    glyph_blank = !in_text || 1'(blank_mask >> d_i);
  end

  oled_digit_font_rom u_font_rom (
    .clk       (clk_in),
    .rst_n     (resetn_in),
    .en        (fetch_en),
    .blank     (glyph_blank),
    .glyph_idx (glyph_idx),
    .glyph_col (glyph_col),
    .byte_q    (data_out)
  );

  assign write_stb_out  = write_stb;
  assign sync_stb_out   = sync_stb;
  assign frame_done_out = done;
  assign busy_out       = (state_q != ST_IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_bcd_oled_renderer.sv
// Directed bench for bcd_oled_renderer: spot-check vector table per frame,
// full-frame comparison against a font model, plus ready/pending/reset sequences.
module tb_bcd_oled_renderer;

  localparam int DIGITS_NUM  = 6;
  localparam int COLS        = 128;
  localparam int PAGES       = 8;
  localparam int TEXT_PAGE   = 3;
  localparam int TEXT_X0     = 40;
  localparam int FRAME_BYTES = COLS * PAGES;
  localparam int FRAME_CYC   = 3 * FRAME_BYTES + 2;

  // ---------------- clock / reset ----------------
  logic                    clk_in       = 1'b0;
  logic                    resetn_in    = 1'b0;
  logic [4*DIGITS_NUM-1:0] digits_in    = '0;
  logic                    frame_stb_in = 1'b0;
  logic                    ready_in     = 1'b0;
  logic                    rand_ready   = 1'b0;
  logic                    sel_b        = 1'b0;

  always #5 clk_in = ~clk_in;

  logic [7:0] data_a, data_b;
  logic       write_a, write_b, sync_a, sync_b, busy_a, busy_b, done_a, done_b;
  logic [2:0] dbg_a, dbg_b;

  bcd_oled_renderer #(
    .DIGITS_NUM(DIGITS_NUM), .COLS(COLS), .PAGES(PAGES),
    .TEXT_PAGE(TEXT_PAGE), .TEXT_X0(TEXT_X0), .BLANK_LEADING(1)
  ) u_dut (
    .clk_in(clk_in), .resetn_in(resetn_in), .digits_in(digits_in),
    .frame_stb_in(frame_stb_in), .ready_in(ready_in), .data_out(data_a),
    .write_stb_out(write_a), .sync_stb_out(sync_a), .busy_out(busy_a),
    .frame_done_out(done_a), .state_dbg(dbg_a)
  );

  bcd_oled_renderer #(
    .DIGITS_NUM(DIGITS_NUM), .COLS(COLS), .PAGES(PAGES),
    .TEXT_PAGE(TEXT_PAGE), .TEXT_X0(TEXT_X0), .BLANK_LEADING(0)
  ) u_dut_nb (
    .clk_in(clk_in), .resetn_in(resetn_in), .digits_in(digits_in),
    .frame_stb_in(frame_stb_in), .ready_in(ready_in), .data_out(data_b),
    .write_stb_out(write_b), .sync_stb_out(sync_b), .busy_out(busy_b),
    .frame_done_out(done_b), .state_dbg(dbg_b)
  );

  wire [7:0] data_m  = sel_b ? data_b  : data_a;
  wire       write_m = sel_b ? write_b : write_a;
  wire       sync_m  = sel_b ? sync_b  : sync_a;
  wire       busy_m  = sel_b ? busy_b  : busy_a;
  wire       done_m  = sel_b ? done_b  : done_a;

  // ---------------- model ----------------
  function automatic logic [7:0] glyph_byte(input logic [3:0] n, input int g);
    logic [39:0] g5;
    case (n)
      4'd0: g5 = 40'h3E_51_49_45_3E;
      4'd1: g5 = 40'h00_42_7F_40_00;
      4'd2: g5 = 40'h42_61_51_49_46;
      4'd3: g5 = 40'h21_41_45_4B_31;
      4'd4: g5 = 40'h18_14_12_7F_10;
      4'd5: g5 = 40'h27_45_45_45_39;
      4'd6: g5 = 40'h3C_4A_49_49_30;
      4'd7: g5 = 40'h01_71_09_05_03;
      4'd8: g5 = 40'h36_49_49_49_36;
      4'd9: g5 = 40'h06_49_49_29_1E;
      default: g5 = 40'h08_08_08_08_08;
    endcase
    if (g > 4) return 8'h00;
    return g5[8*(4-g) +: 8];
  endfunction

  function automatic logic [7:0] exp_byte(input logic [4*DIGITS_NUM-1:0] dg, input bit bl,
                                          input int page, input int col);
    int k, d;
    bit blank;
    if (page != TEXT_PAGE || col < TEXT_X0 || col >= TEXT_X0 + 8 * DIGITS_NUM) return 8'h00;
    k = col - TEXT_X0;
    d = DIGITS_NUM - 1 - k / 8;
    if (bl) begin
      blank = (d != 0);
      for (int j = d; j < DIGITS_NUM; j++) if (dg[4*j +: 4] != 4'd0) blank = 1'b0;
      if (blank) return 8'h00;
    end
    return glyph_byte(dg[4*d +: 4], k % 8);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int n_checks = 0, n_err = 0;
  int sync_cnt, done_cnt, busy_fall, sync_cyc, done_cyc;
  int cyc = 0, hs_err = 0;
  logic prev_acc = 1'b0, prev_wr = 1'b0, prev_sy = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk_in) begin
    cyc++;
    if (resetn_in) begin
      if (write_m && sync_m) hs_err++;
      if (prev_acc && (write_m || sync_m)) hs_err++;
      if (!prev_acc && prev_wr && (!write_m || data_m !== prev_data)) hs_err++;
      if (!prev_acc && prev_sy && !sync_m) hs_err++;
      if (sync_m && sync_cyc < 0) sync_cyc = cyc;
      if (sync_m && ready_in) sync_cnt++;
      if (write_m && ready_in) got_q.push_back(data_m);
      if (done_m) begin done_cnt++; done_cyc = cyc; end
      if (prev_busy && !busy_m) busy_fall++;
      prev_acc  = (write_m || sync_m) && ready_in;
      prev_wr   = write_m;
      prev_sy   = sync_m;
      prev_data = data_m;
      prev_busy = busy_m;
    end else begin
      prev_acc = 1'b0; prev_wr = 1'b0; prev_sy = 1'b0; prev_busy = 1'b0;
    end
  end

  always @(posedge clk_in) begin
    #2;
    if (rand_ready) ready_in = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_frame();
    frame_stb_in = 1'b1;
    tick(1);
    frame_stb_in = 1'b0;
  endtask

  task automatic clear_mon();
    got_q.delete();
    sync_cnt = 0; done_cnt = 0; busy_fall = 0; sync_cyc = -1; done_cyc = -1;
  endtask

  task automatic wait_done(input int n_done, input int budget, output bit ok);
    int t;
    t = 0;
    while (done_cnt < n_done && t < budget) begin tick(1); t++; end
    ok = (done_cnt >= n_done);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input int base,
                             input logic [4*DIGITS_NUM-1:0] dg, input bit bl);
    int bad;
    logic [7:0] gv;
    exp_q.delete();
    for (int i = 0; i < FRAME_BYTES; i++) exp_q.push_back(exp_byte(dg, bl, i / COLS, i % COLS));
    bad = -1;
    gv  = 8'h00;
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (bad < 0) begin
        if (base + i >= got_q.size()) begin bad = i; gv = 8'hxx; end
        else if (got_q[base+i] !== exp_q[i]) begin bad = i; gv = got_q[base+i]; end
      end
    end
    n_checks++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: byte %0d (page %0d col %0d) got %0h expected %0h",
               name, bad, bad / COLS, bad % COLS, gv, exp_q[bad]);
    end
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct { logic [4*DIGITS_NUM-1:0] digits; bit use_nb; } scen_t;
  typedef struct { int scen; int page; int col; logic [7:0] exp; } vec_t;
  scen_t scens[3];
  vec_t  vecs[$];

  task automatic add_vec(input int s, input int p, input int c, input logic [7:0] e);
    vec_t v;
    v.scen = s; v.page = p; v.col = c; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    bit ok;
    int t, idx;
    logic [7:0] gv;

    scens[0] = '{24'h001234, 1'b0};
    scens[1] = '{24'h000000, 1'b0};
    scens[2] = '{24'h00A000, 1'b1};
    add_vec(0, 3, 40, 8'h00); add_vec(0, 3, 47, 8'h00); add_vec(0, 3, 48, 8'h00);
    add_vec(0, 3, 55, 8'h00); add_vec(0, 3, 56, 8'h00); add_vec(0, 3, 57, 8'h42);
    add_vec(0, 3, 58, 8'h7F); add_vec(0, 3, 59, 8'h40); add_vec(0, 3, 60, 8'h00);
    add_vec(0, 3, 61, 8'h00); add_vec(0, 3, 64, 8'h42); add_vec(0, 3, 83, 8'h7F);
    add_vec(0, 2, 57, 8'h00); add_vec(0, 4, 57, 8'h00);
    add_vec(1, 3, 80, 8'h3E); add_vec(1, 3, 81, 8'h51); add_vec(1, 3, 82, 8'h49);
    add_vec(1, 3, 83, 8'h45); add_vec(1, 3, 84, 8'h3E); add_vec(1, 3, 85, 8'h00);
    add_vec(1, 3, 40, 8'h00); add_vec(1, 3, 72, 8'h00); add_vec(1, 3, 79, 8'h00);
    for (int c = 56; c <= 60; c++) add_vec(2, 3, c, 8'h08);
    add_vec(2, 3, 61, 8'h00); add_vec(2, 3, 40, 8'h3E); add_vec(2, 3, 48, 8'h3E);
    add_vec(2, 3, 64, 8'h3E); add_vec(2, 3, 84, 8'h3E); add_vec(2, 0, 0, 8'h00);

    clear_mon();
    tick(3);
    check("reset_outputs_a", {data_a, write_a, sync_a, busy_a, done_a, dbg_a}, 32'd0);
    check("reset_outputs_b", {data_b, write_b, sync_b, busy_b, done_b, dbg_b}, 32'd0);
    resetn_in = 1'b1;
    ready_in  = 1'b1;
    tick(2);

    // Ready held high: three digit patterns.
    for (int s = 0; s < 3; s++) begin
      clear_mon();
      sel_b     = scens[s].use_nb;
      digits_in = scens[s].digits;
      pulse_frame();
      wait_done(1, 4000, ok);
      check($sformatf("s%0d_done_seen", s), 32'(ok), 32'd1);
      tick(4);
      check($sformatf("s%0d_done_cnt", s), done_cnt, 1);
      check($sformatf("s%0d_sync_cnt", s), sync_cnt, 1);
      check($sformatf("s%0d_byte_cnt", s), got_q.size(), FRAME_BYTES);
      check_frame($sformatf("s%0d_frame", s), 0, scens[s].digits, !scens[s].use_nb);
      // Cycles counted inclusively from the first SYNC cycle to the done pulse.
      if (s == 0) check("frame_cycles", done_cyc - sync_cyc + 1, FRAME_CYC);
      foreach (vecs[v]) begin
        if (vecs[v].scen == s) begin
          idx = vecs[v].page * COLS + vecs[v].col;
          gv  = (idx < got_q.size()) ? got_q[idx] : 8'hxx;
          check($sformatf("s%0d_p%0d_c%0d", s, vecs[v].page, vecs[v].col), gv, vecs[v].exp);
        end
      end
    end
    sel_b = 1'b0;

    // Pseudo-random ready: same bytes, strict handshake.
    clear_mon();
    digits_in  = 24'h001234;
    rand_ready = 1'b1;
    pulse_frame();
    wait_done(1, 20000, ok);
    rand_ready = 1'b0;
    tick(1);
    ready_in = 1'b1;
    tick(4);
    check("rand_done_seen", 32'(ok), 32'd1);
    check("rand_sync_cnt", sync_cnt, 1);
    check("rand_byte_cnt", got_q.size(), FRAME_BYTES);
    check_frame("rand_frame", 0, 24'h001234, 1'b1);

    // Pending requests collapse into one follow-on frame with new digits.
    clear_mon();
    digits_in = 24'h001234;
    pulse_frame();
    tick(50);
    digits_in = 24'h000987;
    tick(50);
    pulse_frame();
    tick(100);
    pulse_frame();
    wait_done(2, 8000, ok);
    tick(20);
    check("pend_done_seen", 32'(ok), 32'd1);
    check("pend_done_cnt", done_cnt, 2);
    check("pend_sync_cnt", sync_cnt, 2);
    check("pend_byte_cnt", got_q.size(), 2 * FRAME_BYTES);
    check("pend_busy_falls", busy_fall, 1);
    check("pend_idle_after", 32'(busy_a), 32'd0);
    check_frame("pend_frame1", 0, 24'h001234, 1'b1);
    check_frame("pend_frame2", FRAME_BYTES, 24'h000987, 1'b1);

    // Reset in the middle of a frame.
    clear_mon();
    digits_in = 24'h001234;
    pulse_frame();
    t = 0;
    while (got_q.size() < 500 && t < 3000) begin tick(1); t++; end
    check("rst_reached_500", 32'(got_q.size() >= 500), 32'd1);
    #2 resetn_in = 1'b0;
    #1;
    check("rst_async_outputs", {data_a, write_a, sync_a, busy_a, done_a, dbg_a}, 32'd0);
    tick(3);
    resetn_in = 1'b1;
    tick(5);
    check("rst_no_done", done_cnt, 0);
    check("rst_idle_busy", 32'(busy_a), 32'd0);
    clear_mon();
    pulse_frame();
    wait_done(1, 4000, ok);
    tick(4);
    check("rst_next_done", done_cnt, 1);
    check("rst_next_bytes", got_q.size(), FRAME_BYTES);
    check_frame("rst_next_frame", 0, 24'h001234, 1'b1);

    check("handshake_violations", hs_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
